// File: rtl/manchester_frame_rx_if.sv
// Readout-link receive interface.
//   data_in     raw serial Manchester stream (asynchronous to clk)
//   data_out    last decoded payload, MSB = first bit received
//   data_valid  1-cycle pulse: data_out updated this cycle
//   frame_error 1-cycle pulse: a locked decode was aborted
//   busy        high while payload bits are being collected
// master = stream source / result consumer, slave = decoder.
interface manchester_frame_rx_if #(
   parameter int DATA_LENGTH = 20
);
   logic                   data_in;
   logic [DATA_LENGTH-1:0] data_out;
   logic                   data_valid;
   logic                   frame_error;
   logic                   busy;

   modport master (output data_in, input data_out, data_valid, frame_error, busy);
   modport slave  (input data_in, output data_out, data_valid, frame_error, busy);
endinterface

// File: rtl/manchester_frame_rx.sv
// Manchester frame receiver for the counter readout stream.
// The line carries bit XOR tx-clock, so a rising mid-bit edge is a 1. Each
// frame is the preamble 1010 followed by DATA_LENGTH payload bits, MSB first.
// data_in is oversampled on clk; bit timing is recovered purely from the
// interval between successive edges.
// Ports:
//   clk    oversampling clock
//   reset  synchronous, active-high
//   bus    manchester_frame_rx_if.slave (data_in in; data_out, data_valid,
//          frame_error, busy out)
module manchester_frame_rx #(
   parameter int DATA_LENGTH = 20,
   parameter int BIT_CYCLES  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   manchester_frame_rx_if.slave bus
);
   localparam int SHORT_MIN = BIT_CYCLES / 4;
   localparam int LONG_MIN  = (3 * BIT_CYCLES) / 4;
   localparam int LONG_MAX  = (5 * BIT_CYCLES) / 4;
   localparam int TMO       = LONG_MAX + 1;
   localparam int TW        = $clog2(TMO + 1);
   localparam int CW        = $clog2(DATA_LENGTH + 1);

   localparam logic [TW-1:0] SHORT_MIN_T = TW'(SHORT_MIN);
   localparam logic [TW-1:0] LONG_MIN_T  = TW'(LONG_MIN);
   localparam logic [TW-1:0] LONG_MAX_T  = TW'(LONG_MAX);
   localparam logic [TW-1:0] TMO_T       = TW'(TMO);
   localparam logic [CW-1:0] LAST_BIT    = CW'(DATA_LENGTH - 1);

   typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

   // input path
   logic sync1, sync2, prev;
   logic edge_q, lvl_q;

   // decoder state
   state_t                 state, state_n;
   logic [TW-1:0]          timer;
   logic                   prev_mid, prev_mid_n;
   logic [2:0]             win_hist, win_hist_n;   // three most recent mid-bit values
   logic [DATA_LENGTH-2:0] payload, payload_n;     // payload bits gathered so far
   logic [CW-1:0]          bit_cnt, bit_cnt_n;
   logic [DATA_LENGTH-1:0] data_out_r, data_out_n;
   logic                   valid_r, valid_n;
   logic                   err_r, err_n;

   // edge classification
   logic                   ev_mid, ev_bnd, ev_inv, timeout;
   logic [3:0]             win_sh;
   logic [DATA_LENGTH-1:0] pay_sh;

   // Synchronizer, registered copy, then one more stage so that the edge
   // flag and the post-edge level line up with the interval timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         prev   <= 1'b0;
         edge_q <= 1'b0;
         lvl_q  <= 1'b0;
      end else begin
         sync1  <= bus.data_in;
         sync2  <= sync1;
         prev   <= sync2;
         edge_q <= sync2 ^ prev;
         lvl_q  <= sync2;
      end
   end

   // Cycles since the last edge; the value seen on an edge is its interval.
   always_ff @(posedge clk) begin
      if (reset)             timer <= '0;
      else if (edge_q)       timer <= TW'(1);
      else if (timer != TMO_T) timer <= timer + TW'(1);
   end

   // Short intervals alternate boundary/mid-bit; a long interval always lands
   // on a mid-bit edge, which is the only thing that can acquire lock.
   always_comb begin
      ev_mid = 1'b0;
      ev_bnd = 1'b0;
      ev_inv = 1'b0;
      if (edge_q) begin
         if (timer < SHORT_MIN_T || timer > LONG_MAX_T) begin
            ev_inv = 1'b1;
         end else if (timer < LONG_MIN_T) begin
            if (state != HUNT) begin
               if (prev_mid) ev_bnd = 1'b1;
               else          ev_mid = 1'b1;
            end
         end else begin
            if (prev_mid || state == HUNT) ev_mid = 1'b1;
            else                           ev_inv = 1'b1;
         end
      end
   end

   assign timeout = (state != HUNT) && (timer == TMO_T);
   assign win_sh  = {win_hist, lvl_q};
   assign pay_sh  = {payload, lvl_q};

   always_comb begin
      state_n    = state;
      prev_mid_n = prev_mid;
      win_hist_n = win_hist;
      payload_n  = payload;
      bit_cnt_n  = bit_cnt;
      data_out_n = data_out_r;
      valid_n    = 1'b0;
      err_n      = 1'b0;
      case (state)
         HUNT: begin
            if (ev_mid) begin
               state_n    = SYNC;
               prev_mid_n = 1'b1;
               win_hist_n = win_sh[2:0];
            end
         end
         SYNC: begin
            // timeout takes priority over any edge in the same cycle
            if (timeout || ev_inv) begin
               state_n    = HUNT;
               err_n      = 1'b1;
               prev_mid_n = 1'b0;
               win_hist_n = '0;
            end else if (ev_mid) begin
               prev_mid_n = 1'b1;
               win_hist_n = win_sh[2:0];
               if (win_sh == 4'b1010) begin
                  state_n    = DATA;
                  win_hist_n = '0;
                  bit_cnt_n  = '0;
               end
            end else if (ev_bnd) begin
               prev_mid_n = 1'b0;
            end
         end
         DATA: begin
            if (timeout || ev_inv) begin
               state_n    = HUNT;
               err_n      = 1'b1;
               prev_mid_n = 1'b0;
               win_hist_n = '0;
            end else if (ev_mid) begin
               prev_mid_n = 1'b1;
               payload_n  = pay_sh[DATA_LENGTH-2:0];
               bit_cnt_n  = bit_cnt + CW'(1);
               if (bit_cnt == LAST_BIT) begin
                  // stay locked so a back-to-back preamble is caught
                  data_out_n = pay_sh;
                  valid_n    = 1'b1;
                  state_n    = SYNC;
                  win_hist_n = '0;
               end
            end else if (ev_bnd) begin
               prev_mid_n = 1'b0;
            end
         end
         default: begin
            state_n    = HUNT;
            prev_mid_n = 1'b0;
            win_hist_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HUNT;
         prev_mid   <= 1'b0;
         win_hist   <= '0;
         payload    <= '0;
         bit_cnt    <= '0;
         data_out_r <= '0;
         valid_r    <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state      <= state_n;
         prev_mid   <= prev_mid_n;
         win_hist   <= win_hist_n;
         payload    <= payload_n;
         bit_cnt    <= bit_cnt_n;
         data_out_r <= data_out_n;
         valid_r    <= valid_n;
         err_r      <= err_n;
      end
   end

   assign bus.data_out    = data_out_r;
   assign bus.data_valid  = valid_r;
   assign bus.frame_error = err_r;
   assign bus.busy        = (state == DATA);
endmodule

// File: tb/tb_manchester_frame_rx.sv
module tb_manchester_frame_rx;
   localparam int DL   = 20;
   localparam int BC   = 16;
   localparam int HALF = BC / 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   manchester_frame_rx_if #(.DATA_LENGTH(DL)) bus ();

   manchester_frame_rx #(.DATA_LENGTH(DL), .BIT_CYCLES(BC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // output monitor, sampled on the falling edge
   int v_cnt = 0, e_cnt = 0, both_cnt = 0, busy_cnt = 0;
   logic [DL-1:0] v_dat[$];
   int v_cyc[$];
   int e_cyc[$];
   always @(negedge clk) begin
      if (bus.data_valid) begin
         v_cnt <= v_cnt + 1;
         v_dat.push_back(bus.data_out);
         v_cyc.push_back(cyc);
      end
      if (bus.frame_error) begin
         e_cnt <= e_cnt + 1;
         e_cyc.push_back(cyc);
      end
      if (bus.data_valid && bus.frame_error) both_cnt <= both_cnt + 1;
      if (bus.busy) busy_cnt <= busy_cnt + 1;
   end

   int last_chg = 0;   // posedge at which the latest line change is sampled

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_line(input logic v);
      if (v !== bus.data_in) last_chg = cyc + 1;
      bus.data_in = v;
   endtask

   // line = bit XOR clock, clock high in the first half
   task automatic send_bit(input logic b);
      set_line(~b); hold(HALF);
      set_line(b);  hold(HALF);
   endtask

   // first half carries a 2-cycle inverted pulse starting 2 cycles in
   task automatic send_glitch_bit(input logic b);
      set_line(~b); hold(2);
      set_line(b);  hold(2);
      set_line(~b); hold(HALF - 4);
      set_line(b);  hold(HALF);
   endtask

   task automatic send_idle(input int n);
      repeat (n) send_bit(1'b0);
   endtask

   task automatic send_pre();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
   endtask

   task automatic send_frame(input logic [DL-1:0] d);
      send_pre();
      for (int i = DL - 1; i >= 0; i--) send_bit(d[i]);
   endtask

   int v0, e0, b0;
   logic [DL-1:0] pat;

   initial begin
      bus.data_in = 1'b0;
      reset = 1'b1;
      hold(3);
      chk("rst_data_out", 32'(bus.data_out), 32'h0);
      chk("rst_valid", 32'(bus.data_valid), 32'h0);
      chk("rst_error", 32'(bus.frame_error), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      reset = 1'b0;
      hold(2);

      // preamble-less all-zero stream
      v0 = v_cnt; e0 = e_cnt; b0 = busy_cnt;
      send_idle(200);
      chk("zeros_valid", 32'(v_cnt - v0), 32'd0);
      chk("zeros_error", 32'(e_cnt - e0), 32'd0);
      chk("zeros_busy", 32'(busy_cnt - b0), 32'd0);

      // idle then one frame
      v0 = v_cnt; e0 = e_cnt;
      send_idle(8);
      b0 = busy_cnt;
      send_frame(20'h5A5A3);
      send_idle(2);
      chk("f1_valid_cnt", 32'(v_cnt - v0), 32'd1);
      chk("f1_data_out", 32'(bus.data_out), 32'h5A5A3);
      chk("f1_error", 32'(e_cnt - e0), 32'd0);
      chk("f1_busy_after", 32'(bus.busy), 32'h0);
      chk("f1_busy_len", 32'(busy_cnt - b0), 32'(DL * BC));

      // back-to-back frames
      v0 = v_cnt; e0 = e_cnt;
      send_frame(20'h00000);
      send_frame(20'hFFFFF);
      send_idle(2);
      chk("b2b_valid_cnt", 32'(v_cnt - v0), 32'd2);
      chk("b2b_first", 32'(v_dat[v0]), 32'h00000);
      chk("b2b_second", 32'(v_dat[v0 + 1]), 32'hFFFFF);
      chk("b2b_spacing", 32'(v_cyc[v0 + 1] - v_cyc[v0]), 32'((DL + 4) * BC));
      chk("b2b_error", 32'(e_cnt - e0), 32'd0);

      // frame stalls after 10 payload bits
      send_idle(2);
      v0 = v_cnt; e0 = e_cnt;
      pat = 20'h5A5A3;
      send_pre();
      for (int i = DL - 1; i >= DL - 10; i--) send_bit(pat[i]);
      hold(40);
      chk("stall_err_cnt", 32'(e_cnt - e0), 32'd1);
      chk("stall_err_time", 32'(e_cyc[e0] - last_chg), 32'd24);
      chk("stall_valid", 32'(v_cnt - v0), 32'd0);
      chk("stall_data_out", 32'(bus.data_out), 32'hFFFFF);
      chk("stall_busy", 32'(bus.busy), 32'h0);

      // glitch in payload bit 7, then a clean frame
      send_idle(4);
      v0 = v_cnt; e0 = e_cnt;
      send_pre();
      for (int i = DL - 1; i >= 0; i--) begin
         if (i == DL - 1 - 7) send_glitch_bit(1'b1);
         else                 send_bit(1'b1);
      end
      send_idle(4);
      chk("glitch_no_valid", 32'(v_cnt - v0), 32'd0);
      chk("glitch_err_cnt", 32'(e_cnt - e0), 32'd1);
      chk("glitch_data_out", 32'(bus.data_out), 32'hFFFFF);
      send_frame(20'hA5C3E);
      send_idle(2);
      chk("glitch_next_valid", 32'(v_cnt - v0), 32'd1);
      chk("glitch_next_data", 32'(bus.data_out), 32'hA5C3E);
      chk("glitch_next_err", 32'(e_cnt - e0), 32'd1);

      // reset pulse inside payload bit 12, then a clean frame
      send_idle(2);
      v0 = v_cnt; e0 = e_cnt;
      send_pre();
      for (int i = 0; i < 12; i++) send_bit(1'b0);
      set_line(1'b1); hold(4);
      reset = 1'b1;
      hold(1);
      reset = 1'b0;
      chk("midrst_data_out", 32'(bus.data_out), 32'h0);
      chk("midrst_busy", 32'(bus.busy), 32'h0);
      hold(HALF - 5);
      set_line(1'b0); hold(HALF);
      for (int i = 13; i < DL; i++) send_bit(1'b0);
      chk("midrst_no_valid", 32'(v_cnt - v0), 32'd0);
      chk("midrst_no_err", 32'(e_cnt - e0), 32'd0);
      send_idle(4);
      send_frame(20'h12345);
      send_idle(2);
      chk("midrst_valid", 32'(v_cnt - v0), 32'd1);
      chk("midrst_data", 32'(bus.data_out), 32'h12345);
      chk("midrst_err", 32'(e_cnt - e0), 32'd0);

      chk("never_both", 32'(both_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
